gtech_xorn_pipe: RTL and testbench

Parametrised, pipelined successor of the two-input XOR generic cell. It computes a WIDTH-bit bitwise XOR or XNOR of two operands, or folds that XOR into a running accumulator, through a STAGES-deep valid/ready pipeline. It also produces an optional even-parity bit. It sits in the generic technology library and serves datapaths that need registered XOR/XNOR, checksum folding or parity generation under backpressure.

---
 rtl/gtech_xorn_pipe.sv | 114 +++++++++++
 tb/tb_gtech_xorn_pipe.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/gtech_xorn_pipe.sv
// Pipelined WIDTH-bit XOR/XNOR/accumulate cell with valid/ready handshake.
// Define GTECH_XORN_PARITY_EN to build the even-parity output P (tied to 0 otherwise).
module gtech_xorn_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       MODE,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] Z,
    output logic             P
);

    localparam logic [1:0] MODE_XOR  = 2'b00;
    localparam logic [1:0] MODE_ACC  = 2'b01;
    localparam logic [1:0] MODE_LOAD = 2'b10;
    localparam logic [1:0] MODE_XNOR = 2'b11;

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] ld;
    logic [WIDTH-1:0]  dat [STAGES];
    logic [WIDTH-1:0]  acc;
    logic [WIDTH-1:0]  res;
    logic              accept;

    // A stage loads when empty or when its successor loads; bubbles collapse.
    always_comb begin : load_chain
        logic carry;
        carry = OUT_READY;
        ld    = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            ld[k] = ~vld[k] | carry;
            carry = ld[k];
        end
    end

    assign IN_READY = ld[0];
    assign accept   = IN_VALID & IN_READY;

    always_comb begin
        res = A ^ B;
        case (MODE)
            MODE_XOR:  res = A ^ B;
            MODE_ACC:  res = acc ^ A ^ B;
            MODE_LOAD: res = A ^ B;
            MODE_XNOR: res = ~(A ^ B);
            default:   res = A ^ B;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            acc    <= '0;
            vld[0] <= 1'b0;
            dat[0] <= '0;
        end else begin
            if (accept && (MODE == MODE_ACC || MODE == MODE_LOAD))
                acc <= res;
            if (ld[0]) begin
                vld[0] <= accept;
                if (accept)
                    dat[0] <= res;
            end
        end
    end

    for (genvar k = 1; k < STAGES; k++) begin : g_stage
        always_ff @(posedge CLK) begin
            if (RST) begin
                vld[k] <= 1'b0;
                dat[k] <= '0;
            end else if (ld[k]) begin
                vld[k] <= vld[k-1];
                if (vld[k-1])
                    dat[k] <= dat[k-1];
            end
        end
    end

    assign OUT_VALID = vld[STAGES-1];
    assign Z         = dat[STAGES-1];

`ifdef GTECH_XORN_PARITY_EN
    // Parity travels alongside the data so it holds exactly when Z holds.
    logic par [STAGES];

    always_ff @(posedge CLK) begin
        if (RST)
            par[0] <= 1'b0;
        else if (ld[0] && accept)
            par[0] <= ^res;
    end

    for (genvar k = 1; k < STAGES; k++) begin : g_par
        always_ff @(posedge CLK) begin
            if (RST)
                par[k] <= 1'b0;
            else if (ld[k] && vld[k-1])
                par[k] <= par[k-1];
        end
    end

    assign P = par[STAGES-1];
`else
    assign P = 1'b0;
`endif

endmodule

// File: tb/tb_gtech_xorn_pipe.sv
// Scoreboard bench for gtech_xorn_pipe (WIDTH=8, STAGES=2) using directed vectors.
module tb_gtech_xorn_pipe;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       IN_VALID = 1'b0;
    logic       IN_READY;
    logic [7:0] A = '0;
    logic [7:0] B = '0;
    logic [1:0] MODE = '0;
    logic       OUT_VALID;
    logic       OUT_READY = 1'b1;
    logic [7:0] Z;
    logic       P;

    int checks = 0;
    int errors = 0;
    int accepted = 0;
    logic [8:0] sb_q [$];

    gtech_xorn_pipe #(.WIDTH(8), .STAGES(2)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .A(A), .B(B), .MODE(MODE), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .Z(Z), .P(P)
    );

    always #5 CLK = ~CLK;

    function automatic logic exp_par(input logic p);
`ifdef GTECH_XORN_PARITY_EN
        return p;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Drives one beat; returns after the accepting edge with the number of stalled cycles.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m,
                        input logic [7:0] z_exp, input logic p_exp, output int stalls);
        stalls   = 0;
        IN_VALID = 1'b1;
        A = a; B = b; MODE = m;
        for (int t = 0; t < 200; t++) begin
            @(negedge CLK);
            if (IN_READY) begin
                sb_q.push_back({exp_par(p_exp), z_exp});
                @(posedge CLK);
                #1;
                accepted++;
                IN_VALID = 1'b0;
                return;
            end
            stalls++;
            @(posedge CLK);
            #1;
        end
        check("send_timeout", 32'd1, 32'd0);
        IN_VALID = 1'b0;
    endtask

    // Monitor: every output transfer must match the head of the scoreboard.
    always @(negedge CLK) begin
        if (!RST && OUT_VALID && OUT_READY) begin
            if (sb_q.size() == 0) begin
                check("unexpected_beat", {23'd0, P, Z}, 32'hFFFF_FFFF);
            end else begin
                logic [8:0] e;
                e = sb_q.pop_front();
                check("beat_z", {24'd0, Z}, {24'd0, e[7:0]});
                check("beat_p", {31'd0, P}, {31'd0, e[8]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int st_sum;

        // Reset and idle
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        check("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
        check("rst_z", {24'd0, Z}, 32'd0);
        check("rst_p", {31'd0, P}, 32'd0);
        check("rst_in_ready", {31'd0, IN_READY}, 32'd1);

        // Single xor with latency check
        send(8'hA5, 8'h0F, 2'b00, 8'hAA, 1'b0, st);
        check("lat_not_yet", {31'd0, OUT_VALID}, 32'd0);
        @(posedge CLK); #1;
        check("lat_valid", {31'd0, OUT_VALID}, 32'd1);
        check("lat_z", {24'd0, Z}, 32'hAA);
        @(posedge CLK); #1;
        check("single_one_beat", {31'd0, OUT_VALID}, 32'd0);

        // Back-to-back accumulate chain at full throughput
        st_sum = 0;
        send(8'h01, 8'h00, 2'b10, 8'h01, 1'b1, st); st_sum += st;
        send(8'h02, 8'h00, 2'b01, 8'h03, 1'b0, st); st_sum += st;
        send(8'h04, 8'h10, 2'b01, 8'h17, 1'b0, st); st_sum += st;
        check("chain_no_stall", st_sum, 32'd0);
        check("chain_z_last_in_flight", {31'd0, OUT_VALID}, 32'd1);
        repeat (3) @(posedge CLK);
        #1;

        // Xnor leaves ACC alone
        send(8'hFF, 8'h0F, 2'b11, 8'h0F, 1'b0, st);
        send(8'h00, 8'h00, 2'b01, 8'h17, 1'b0, st);
        repeat (3) @(posedge CLK);
        #1;

        // Backpressure: 5 beats with OUT_READY low, released later
        OUT_READY = 1'b0;
        accepted  = 0;
        fork
            begin
                for (int i = 1; i <= 5; i++) begin
                    logic [7:0] zz;
                    zz = 8'hF0 ^ 8'(i);
                    send(8'(i), 8'hF0, 2'b00, zz, ^zz, st);
                end
            end
            begin
                repeat (5) @(posedge CLK);
                #2;
                check("bp_accepts", accepted, 32'd2);
                check("bp_in_ready", {31'd0, IN_READY}, 32'd0);
                check("bp_out_valid", {31'd0, OUT_VALID}, 32'd1);
                check("bp_z_hold", {24'd0, Z}, 32'hF1);
                check("bp_p_hold", {31'd0, P}, {31'd0, exp_par(1'b1)});
                OUT_READY = 1'b1;
            end
        join
        repeat (4) @(posedge CLK);
        #1;
        check("bp_drained", sb_q.size(), 32'd0);

        // Reset with two beats in flight
        OUT_READY = 1'b0;
        send(8'h55, 8'h00, 2'b10, 8'h55, 1'b0, st);
        send(8'h12, 8'h34, 2'b00, 8'h26, 1'b1, st);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        sb_q.delete();
        check("midrst_out_valid", {31'd0, OUT_VALID}, 32'd0);
        check("midrst_in_ready", {31'd0, IN_READY}, 32'd1);
        OUT_READY = 1'b1;
        send(8'h33, 8'h00, 2'b01, 8'h33, 1'b0, st);
        repeat (4) @(posedge CLK);
        #1;
        check("final_drained", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
